// File: rtl/insn_encoder.sv
// RV32I instruction encoder that writes encoded words into an instruction memory and can pad the rest of it with NOP.
// Optional immediate range checking is enabled by defining INSN_ENC_RANGE_CHECK_EN.
module insn_encoder #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              fill_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [2:0]        FMT_R    = 3'd0;
  localparam logic [2:0]        FMT_I    = 3'd1;
  localparam logic [2:0]        FMT_S    = 3'd2;
  localparam logic [2:0]        FMT_SB   = 3'd3;
  localparam logic [2:0]        FMT_U    = 3'd4;
  localparam logic [2:0]        FMT_UJ   = 3'd5;
  localparam logic [31:0]       NOP      = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wptr, wptr_nxt;
  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [31:0]         mem_wdata_nxt;
  logic                done_nxt;
  logic                err_nxt;

  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                range_err;
  logic                enc_err;

  // Field placement per format; unused fields never reach the word
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (fmt)
      FMT_R:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   enc_word = {imm[31:12], rd, opcode};
      FMT_UJ:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word    = NOP;
        enc_illegal = 1'b1;
      end
    endcase
  end

`ifdef INSN_ENC_RANGE_CHECK_EN
  // Flag immediates that do not survive truncation into their field
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (imm[31:11] != {21{imm[11]}});
      FMT_SB:       range_err = (imm[31:12] != {20{imm[12]}}) | imm[0];
      FMT_U:        range_err = |imm[11:0];
      FMT_UJ:       range_err = (imm[31:20] != {12{imm[20]}}) | imm[0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err  = enc_illegal | range_err;
  assign in_ready = (state == IDLE) && !fill_req && !reset;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next state; outputs are computed one cycle ahead so they are valid throughout WRITE/FILL
  always_comb begin
    state_nxt     = state;
    wptr_nxt      = wptr;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    done_nxt      = 1'b0;
    err_nxt       = err;
    case (state)
      IDLE: begin
        if (fill_req) begin
          state_nxt     = FILL;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wptr;
          mem_wdata_nxt = NOP;
        end else if (in_valid) begin
          state_nxt     = WRITE;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wptr;
          mem_wdata_nxt = enc_word;
          err_nxt       = err | enc_err;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        wptr_nxt  = wptr + ADDR_ONE;
      end
      FILL: begin
        wptr_nxt = wptr + ADDR_ONE;
        if (wptr == ADDR_MAX) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wptr + ADDR_ONE;
          mem_wdata_nxt = NOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
